// File: rtl/alu_control_md.sv
// ALU control for the multi-cycle MIPS datapath.
// Decodes alu_op/funct into an ALU operation select, drives the HI/LO write
// enables and result mux select, and sequences iterative MULT/MULTU/DIV/DIVU
// with a latency counter, producing busy/stall so the control FSM interlocks
// MFHI/MFLO and back-to-back mul/div behind an in-flight operation.
// Optional feature: define ALU_CTRL_MTHILO_EN to decode MTHI/MTLO.

package alu_pkg;
  typedef enum logic [3:0] {
    C_ADD_U  = 4'd0,
    C_SUB_U  = 4'd1,
    C_AND    = 4'd2,
    C_OR     = 4'd3,
    C_XOR    = 4'd4,
    C_SLT    = 4'd5,
    C_SLT_U  = 4'd6,
    C_SLL    = 4'd7,
    C_SRL    = 4'd8,
    C_SRA    = 4'd9,
    C_MULT   = 4'd10,
    C_MULT_U = 4'd11,
    C_DIV    = 4'd12,
    C_DIV_U  = 4'd13,
    C_PASS_A = 4'd14
  } alu_sel_t;

  // alu_op encodings
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  // RTYPE funct encodings
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
endpackage

module alu_control_md
  import alu_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] alu_op,
  input  logic [5:0] ir_5_to_0,
  output logic       hi_en,
  output logic       lo_en,
  output logic [1:0] alu_lo_hi,
  output alu_sel_t   opsel,
  output logic       busy,
  output logic       stall,
  output logic       illegal
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

  // Counter preloads: the FSM spends exactly LATENCY cycles in MUL/DIV.
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LATENCY - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  alu_sel_t         r_op;

  logic     w_en;
  logic     w_busy;
  alu_sel_t w_dec_op;
  logic     w_legal;
  logic     w_md;
  logic     w_is_mul;
  logic     w_mfhi;
  logic     w_mflo;
  logic     w_mthi;
  logic     w_mtlo;
  logic     w_issue_md;

  // Issue strobe is ignored while reset is held so every output sits at its
  // reset value regardless of what the control FSM is driving.
  assign w_en   = en & ~rst;
  assign w_busy = (r_state != S_IDLE);

  // Instruction decode: operation select plus class flags for interlocking.
  always_comb begin
    w_dec_op = C_ADD_U;
    w_legal  = 1'b0;
    w_md     = 1'b0;
    w_is_mul = 1'b0;
    w_mfhi   = 1'b0;
    w_mflo   = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    if (alu_op == OP_RTYPE) begin
      case (ir_5_to_0)
        FN_ADDU:  begin w_dec_op = C_ADD_U; w_legal = 1'b1; end
        FN_SUBU:  begin w_dec_op = C_SUB_U; w_legal = 1'b1; end
        FN_AND:   begin w_dec_op = C_AND;   w_legal = 1'b1; end
        FN_OR:    begin w_dec_op = C_OR;    w_legal = 1'b1; end
        FN_XOR:   begin w_dec_op = C_XOR;   w_legal = 1'b1; end
        FN_SLT:   begin w_dec_op = C_SLT;   w_legal = 1'b1; end
        FN_SLTU:  begin w_dec_op = C_SLT_U; w_legal = 1'b1; end
        FN_SLL:   begin w_dec_op = C_SLL;   w_legal = 1'b1; end
        FN_SRL:   begin w_dec_op = C_SRL;   w_legal = 1'b1; end
        FN_SRA:   begin w_dec_op = C_SRA;   w_legal = 1'b1; end
        FN_MFHI:  begin w_dec_op = C_ADD_U; w_legal = 1'b1; w_mfhi = 1'b1; end
        FN_MFLO:  begin w_dec_op = C_ADD_U; w_legal = 1'b1; w_mflo = 1'b1; end
        FN_MULT:  begin w_dec_op = C_MULT;   w_legal = 1'b1; w_md = 1'b1; w_is_mul = 1'b1; end
        FN_MULTU: begin w_dec_op = C_MULT_U; w_legal = 1'b1; w_md = 1'b1; w_is_mul = 1'b1; end
        FN_DIV:   begin w_dec_op = C_DIV;    w_legal = 1'b1; w_md = 1'b1; end
        FN_DIVU:  begin w_dec_op = C_DIV_U;  w_legal = 1'b1; w_md = 1'b1; end
`ifdef ALU_CTRL_MTHILO_EN
        FN_MTHI:  begin w_dec_op = C_PASS_A; w_legal = 1'b1; w_mthi = 1'b1; end
        FN_MTLO:  begin w_dec_op = C_PASS_A; w_legal = 1'b1; w_mtlo = 1'b1; end
`endif
        default:  begin w_dec_op = C_ADD_U; w_legal = 1'b0; end
      endcase
    end else begin
      case (alu_op)
        OP_ADDIU: begin w_dec_op = C_ADD_U; w_legal = 1'b1; end
        OP_SLTI:  begin w_dec_op = C_SLT;   w_legal = 1'b1; end
        OP_ANDI:  begin w_dec_op = C_AND;   w_legal = 1'b1; end
        OP_ORI:   begin w_dec_op = C_OR;    w_legal = 1'b1; end
        default:  begin w_dec_op = C_ADD_U; w_legal = 1'b0; end
      endcase
    end
  end

  // Interlock and output drive: anything touching HI/LO waits out a busy unit.
  always_comb begin
    busy      = w_busy;
    stall     = w_en & w_busy & (w_mfhi | w_mflo | w_md | w_mthi | w_mtlo);
    illegal   = w_en & ~w_legal;
    opsel     = w_busy ? r_op : w_dec_op;
    alu_lo_hi = 2'b00;
    if (w_en && !stall) begin
      if (w_mfhi)      alu_lo_hi = 2'b10;
      else if (w_mflo) alu_lo_hi = 2'b01;
    end
    hi_en      = (r_state == S_WB) | (w_en & ~w_busy & w_mthi);
    lo_en      = (r_state == S_WB) | (w_en & ~w_busy & w_mtlo);
    w_issue_md = w_en & w_md & ~w_busy;
  end

  // Mul/div sequencer: capture the op at issue, count down, one WB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= C_ADD_U;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue_md) begin
            r_op <= w_dec_op;
            if (w_is_mul) begin
              r_state <= S_MUL;
              r_cnt   <= MUL_CNT_INIT;
            end else begin
              r_state <= S_DIV;
              r_cnt   <= DIV_CNT_INIT;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (r_cnt == '0) r_state <= S_WB;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Self-checking bench for alu_control_md (default parameters: MUL 4, DIV 32).
// Expected outputs come from a small busy-window model pushed to a scoreboard
// queue when stimulus is driven and popped when the outputs are sampled.
module tb_alu_control_md;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] alu_op;
  logic [5:0] funct;
  logic       hi_en, lo_en, busy, stall, illegal;
  logic [1:0] alu_lo_hi;
  alu_sel_t   opsel;

  alu_control_md dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .alu_op    (alu_op),
    .ir_5_to_0 (funct),
    .hi_en     (hi_en),
    .lo_en     (lo_en),
    .alu_lo_hi (alu_lo_hi),
    .opsel     (opsel),
    .busy      (busy),
    .stall     (stall),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hi_en;
    logic       lo_en;
    logic [1:0] lohi;
    alu_sel_t   opsel;
    logic       busy;
    logic       stall;
    logic       illegal;
  } exp_t;

  exp_t     sb_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       m_remain = 0;      // busy cycles still to come, including WB
  alu_sel_t m_op     = C_ADD_U;
  int       m_next_remain;
  alu_sel_t m_next_op;

  // last sampled outputs, for directed checks
  logic       g_hi, g_lo, g_busy, g_stall, g_ill;
  logic [1:0] g_lohi;
  alu_sel_t   g_opsel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void tb_decode(input logic [5:0] op, input logic [5:0] fn,
                                     output alu_sel_t o, output logic legal,
                                     output logic md, output logic mfhi, output logic mflo,
                                     output logic mthi, output logic mtlo);
    o = C_ADD_U; legal = 1'b1; md = 1'b0; mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h21: o = C_ADD_U;
        6'h23: o = C_SUB_U;
        6'h24: o = C_AND;
        6'h25: o = C_OR;
        6'h26: o = C_XOR;
        6'h2A: o = C_SLT;
        6'h2B: o = C_SLT_U;
        6'h00: o = C_SLL;
        6'h02: o = C_SRL;
        6'h03: o = C_SRA;
        6'h10: mfhi = 1'b1;
        6'h12: mflo = 1'b1;
        6'h18: begin o = C_MULT;   md = 1'b1; end
        6'h19: begin o = C_MULT_U; md = 1'b1; end
        6'h1A: begin o = C_DIV;    md = 1'b1; end
        6'h1B: begin o = C_DIV_U;  md = 1'b1; end
`ifdef ALU_CTRL_MTHILO_EN
        6'h11: begin o = C_PASS_A; mthi = 1'b1; end
        6'h13: begin o = C_PASS_A; mtlo = 1'b1; end
`endif
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h09: o = C_ADD_U;
        6'h0A: o = C_SLT;
        6'h0C: o = C_AND;
        6'h0D: o = C_OR;
        default: legal = 1'b0;
      endcase
    end
  endfunction

  // Model the cycle's outputs and next busy window; push the expectation.
  task automatic model_push(input logic e, input logic [5:0] op, input logic [5:0] fn);
    exp_t     x;
    alu_sel_t d;
    logic     legal, md, mfhi, mflo, mthi, mtlo, b, wb;
    tb_decode(op, fn, d, legal, md, mfhi, mflo, mthi, mtlo);
    b  = (m_remain > 0);
    wb = (m_remain == 1);
    x.busy    = b;
    x.illegal = e & ~legal;
    x.stall   = e & b & (mfhi | mflo | md | mthi | mtlo);
    x.lohi    = (e && !x.stall && mfhi) ? 2'b10 : (e && !x.stall && mflo) ? 2'b01 : 2'b00;
    x.opsel   = b ? m_op : d;
    x.hi_en   = wb | (e & ~b & mthi);
    x.lo_en   = wb | (e & ~b & mtlo);
    sb_q.push_back(x);
    m_next_remain = m_remain;
    m_next_op     = m_op;
    if (b) m_next_remain = m_remain - 1;
    else if (e && md) begin
      m_next_remain = ((d == C_MULT) || (d == C_MULT_U)) ? 5 : 33;
      m_next_op     = d;
    end
  endtask

  task automatic compare_pop();
    exp_t x;
    x = sb_q.pop_front();
    g_hi = hi_en; g_lo = lo_en; g_busy = busy; g_stall = stall;
    g_ill = illegal; g_lohi = alu_lo_hi; g_opsel = opsel;
    chk("hi_en",     32'(hi_en),     32'(x.hi_en));
    chk("lo_en",     32'(lo_en),     32'(x.lo_en));
    chk("alu_lo_hi", 32'(alu_lo_hi), 32'(x.lohi));
    chk("opsel",     32'(opsel),     32'(x.opsel));
    chk("busy",      32'(busy),      32'(x.busy));
    chk("stall",     32'(stall),     32'(x.stall));
    chk("illegal",   32'(illegal),   32'(x.illegal));
  endtask

  // One clock cycle: drive at negedge, check mid-low-phase, advance at posedge.
  task automatic step(input logic r, input logic e, input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    rst = r; en = e; alu_op = op; funct = fn;
    if (r) begin m_remain = 0; m_op = C_ADD_U; end
    model_push(e & ~r, op, fn);
    #2;
    compare_pop();
    @(posedge clk);
    m_remain = m_next_remain;
    m_op     = m_next_op;
  endtask

  logic [5:0] fn_tab [20];
  logic [5:0] op_tab [8];
  logic [5:0] dec_fn [5];
  alu_sel_t   dec_ex [5];
  logic [5:0] bmask, hmask;
  int         hi_pulses, stall_cnt;
  logic       found;

  initial begin
    fn_tab = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03,
               6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h3F, 6'h07};
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h05};
    dec_fn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
    dec_ex = '{C_ADD_U, C_SUB_U, C_AND, C_OR, C_SLT};
    rst = 1'b1; en = 1'b0; alu_op = 6'h00; funct = 6'h00;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'($urandom), 6'($urandom), 6'($urandom));
      chk("rst_busy", 32'(g_busy), 32'd0);
      chk("rst_hilo", 32'({g_hi, g_lo, g_stall, g_ill, g_lohi}), 32'd0);
    end
    step(1'b0, 1'b0, 6'h00, 6'h21);

    // plain decode, RTYPE then immediates
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 6'h00, dec_fn[i]);
      chk("dec_opsel", 32'(g_opsel), 32'(dec_ex[i]));
    end
    step(1'b0, 1'b1, 6'h09, 6'h3F);
    chk("addiu_opsel", 32'(g_opsel), 32'(C_ADD_U));
    step(1'b0, 1'b1, 6'h0D, 6'h3F);
    chk("ori_opsel", 32'(g_opsel), 32'(C_OR));

    // MULT timing window
    step(1'b0, 1'b1, 6'h00, 6'h18);
    bmask = '0; hmask = '0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 6'h00, 6'h21);
      bmask[k] = g_busy; hmask[k] = g_hi & g_lo;
      if (g_busy) chk("mult_opsel", 32'(g_opsel), 32'(C_MULT));
    end
    chk("mult_busy_win", 32'(bmask), 32'h1F);
    chk("mult_wb_win",   32'(hmask), 32'h10);

    // reset during MUL at cnt=2: no enable pulse afterwards
    step(1'b0, 1'b1, 6'h00, 6'h19);
    step(1'b0, 1'b0, 6'h00, 6'h21);
    step(1'b1, 1'b0, 6'h00, 6'h21);
    chk("rst_mid_busy", 32'(g_busy), 32'd0);
    hi_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 6'h00, 6'h21);
      if (g_hi || g_lo || g_busy) hi_pulses++;
    end
    chk("rst_mid_quiet", 32'(hi_pulses), 32'd0);

    // DIVU then MFLO held; a DIV attempted mid-flight must be refused
    step(1'b0, 1'b1, 6'h00, 6'h1B);
    stall_cnt = 0; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (i == 10) begin
        step(1'b0, 1'b1, 6'h00, 6'h1A);
        chk("div_reissue_stall", 32'(g_stall), 32'd1);
      end else begin
        step(1'b0, 1'b1, 6'h00, 6'h12);
      end
      if (g_stall) stall_cnt++;
      else found = 1'b1;
    end
    chk("mflo_found", 32'(found), 32'd1);
    chk("mflo_stall_len", 32'(stall_cnt), 32'd33);
    chk("mflo_lohi", 32'(g_lohi), 32'd1);
    step(1'b0, 1'b0, 6'h00, 6'h21);
    chk("div_not_taken", 32'(g_busy), 32'd0);

    // illegal funct and MTHI
    step(1'b0, 1'b1, 6'h00, 6'h3F);
    chk("ill_flag", 32'(g_ill), 32'd1);
    chk("ill_opsel", 32'(g_opsel), 32'(C_ADD_U));
    step(1'b0, 1'b1, 6'h00, 6'h11);
`ifdef ALU_CTRL_MTHILO_EN
    chk("mthi_hi_en", 32'(g_hi), 32'd1);
    chk("mthi_opsel", 32'(g_opsel), 32'(C_PASS_A));
`else
    chk("mthi_illegal", 32'(g_ill), 32'd1);
    chk("mthi_no_en", 32'(g_hi), 32'd0);
`endif
    step(1'b0, 1'b0, 6'h00, 6'h11);
    chk("mthi_one_cycle", 32'(g_hi), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom),
           op_tab[$urandom_range(0, 7)], fn_tab[$urandom_range(0, 19)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
